// File: rtl/decode_issue_stage.sv
// decode_issue_stage: registered decode-to-EX control boundary with bubble insertion,
// a programmable post-flush shadow and a saturating bubble counter.
module decode_issue_stage #(
  parameter int ALU_W        = 4,
  parameter int CTRL_W       = 8,
  parameter int KILL_BIT     = 7,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_MODE   = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ALU_W-1:0]  alu_op,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              clr_count,
  output logic              o_valid,
  output logic [ALU_W-1:0]  o_alu_op,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_bubble,
  output logic              o_flushing,
  output logic [CNT_W-1:0]  bubble_count
);
  localparam logic RUN = 1'b0;
  localparam logic FLUSH = 1'b1;
  localparam int SW = $clog2(FLUSH_CYCLES + 1);
  // shadow cycles remaining after the flush edge, minus the one that exits FLUSH
  localparam logic [SW-1:0] RELOAD = FLUSH_CYCLES > 1 ? SW'(FLUSH_CYCLES - 2) : '0;
  logic              state, state_n;
  logic [SW-1:0]     cnt, cnt_n;
  logic              hold, bub;
  logic              valid_n, bubble_n;
  logic [ALU_W-1:0]  alu_n;
  logic [CTRL_W-1:0] ctrl_n;
  logic [CNT_W-1:0]  count_n;
  always_comb begin
    hold     = !flush && state == RUN && stall && STALL_MODE == 1;
    bub      = flush || state == FLUSH || stall || ctrl[KILL_BIT] || !in_valid;
    valid_n  = hold ? o_valid : !bub;
    alu_n    = hold ? o_alu_op : (bub ? '0 : alu_op);
    ctrl_n   = hold ? o_ctrl : (bub ? '0 : ctrl);
    bubble_n = hold ? o_bubble : bub;
    state_n  = flush ? (FLUSH_CYCLES > 1 ? FLUSH : RUN) :
               (state == FLUSH && cnt != '0) ? FLUSH : RUN;
    cnt_n    = flush ? RELOAD : (state == FLUSH && cnt != '0) ? cnt - 1'b1 : cnt;
    count_n  = clr_count ? '0 :
               (bubble_n && bubble_count != '1) ? bubble_count + 1'b1 : bubble_count;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      cnt          <= '0;
      o_valid      <= 1'b0;
      o_alu_op     <= '0;
      o_ctrl       <= '0;
      o_bubble     <= 1'b1;
      bubble_count <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      o_valid      <= valid_n;
      o_alu_op     <= alu_n;
      o_ctrl       <= ctrl_n;
      o_bubble     <= bubble_n;
      bubble_count <= count_n;
    end
  end
  assign o_flushing = state == FLUSH;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed vectors against two instances differing only in stall mode.
module tb_decode_issue_stage;
  logic clk = 1'b0, rst_n = 1'b1;
  logic stall = 0, flush = 0, in_valid = 0, clr_count = 0;
  logic [3:0] alu_op = '0;
  logic [7:0] ctrl = '0;
  logic v0, v1, b0, b1, f0, f1;
  logic [3:0] a0, a1, n0, n1;
  logic [7:0] c0, c1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(.FLUSH_CYCLES(3), .STALL_MODE(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_op(alu_op), .ctrl(ctrl), .clr_count(clr_count), .o_valid(v0), .o_alu_op(a0),
    .o_ctrl(c0), .o_bubble(b0), .o_flushing(f0), .bubble_count(n0));
  decode_issue_stage #(.FLUSH_CYCLES(3), .STALL_MODE(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_op(alu_op), .ctrl(ctrl), .clr_count(clr_count), .o_valid(v1), .o_alu_op(a1),
    .o_ctrl(c1), .o_bubble(b1), .o_flushing(f1), .bubble_count(n1));

  typedef struct {
    logic st, fl, iv, clr;
    logic [3:0] a;
    logic [7:0] c;
    logic ev;
    logic [3:0] ea;
    logic [7:0] ec;
    logic eb, ef;
    logic [3:0] en;
  } vec_t;
  vec_t vt[19];

  function automatic vec_t mk(logic st, logic fl, logic iv, logic clr, logic [3:0] a,
                              logic [7:0] c, logic ev, logic [3:0] ea, logic [7:0] ec,
                              logic eb, logic ef, logic [3:0] en);
    vec_t r;
    r.st = st; r.fl = fl; r.iv = iv; r.clr = clr; r.a = a; r.c = c;
    r.ev = ev; r.ea = ea; r.ec = ec; r.eb = eb; r.ef = ef; r.en = en;
    return r;
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check(input int d, input string tag, input logic ev, input logic [3:0] ea,
                       input logic [7:0] ec, input logic eb, input logic ef, input logic [3:0] en);
    string p;
    p = $sformatf("%s dut%0d", tag, d);
    chk({p, " valid"}, d == 0 ? int'(v0) : int'(v1), int'(ev));
    chk({p, " alu"},   d == 0 ? int'(a0) : int'(a1), int'(ea));
    chk({p, " ctrl"},  d == 0 ? int'(c0) : int'(c1), int'(ec));
    chk({p, " bubble"}, d == 0 ? int'(b0) : int'(b1), int'(eb));
    chk({p, " flushing"}, d == 0 ? int'(f0) : int'(f1), int'(ef));
    chk({p, " count"}, d == 0 ? int'(n0) : int'(n1), int'(en));
  endtask

  task automatic drive(input logic st, input logic fl, input logic iv, input logic clr,
                       input logic [3:0] a, input logic [7:0] c);
    stall = st; flush = fl; in_valid = iv; clr_count = clr; alu_op = a; ctrl = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = mk(0,0,1,0, 4'h5, 8'h13, 1, 4'h5, 8'h13, 0, 0, 0);
    vt[1]  = mk(0,0,1,0, 4'h5, 8'h93, 0, 0, 0, 1, 0, 1);
    vt[2]  = mk(0,0,0,0, 4'h5, 8'h13, 0, 0, 0, 1, 0, 2);
    vt[3]  = mk(0,0,1,0, 4'h3, 8'h22, 1, 4'h3, 8'h22, 0, 0, 2);
    vt[4]  = mk(0,1,1,0, 4'h3, 8'h22, 0, 0, 0, 1, 1, 3);
    vt[5]  = mk(0,0,1,0, 4'h3, 8'h22, 0, 0, 0, 1, 1, 4);
    vt[6]  = mk(0,0,1,0, 4'h3, 8'h22, 0, 0, 0, 1, 0, 5);
    vt[7]  = mk(0,0,1,0, 4'h3, 8'h22, 1, 4'h3, 8'h22, 0, 0, 5);
    vt[8]  = mk(0,1,1,0, 4'h3, 8'h22, 0, 0, 0, 1, 1, 6);
    vt[9]  = mk(0,0,1,0, 4'h3, 8'h22, 0, 0, 0, 1, 1, 7);
    vt[10] = mk(0,1,1,0, 4'h3, 8'h22, 0, 0, 0, 1, 1, 8);
    vt[11] = mk(0,0,1,0, 4'h3, 8'h22, 0, 0, 0, 1, 1, 9);
    vt[12] = mk(0,0,1,0, 4'h3, 8'h22, 0, 0, 0, 1, 0, 10);
    vt[13] = mk(0,0,1,0, 4'h5, 8'h13, 1, 4'h5, 8'h13, 0, 0, 10);
    vt[14] = mk(0,0,1,1, 4'h5, 8'h13, 1, 4'h5, 8'h13, 0, 0, 0);
    vt[15] = mk(1,1,1,0, 4'h5, 8'h13, 0, 0, 0, 1, 1, 1);
    vt[16] = mk(0,0,1,0, 4'h5, 8'h13, 0, 0, 0, 1, 1, 2);
    vt[17] = mk(0,0,1,0, 4'h5, 8'h13, 0, 0, 0, 1, 0, 3);
    vt[18] = mk(0,0,1,0, 4'h5, 8'h13, 1, 4'h5, 8'h13, 0, 0, 3);

    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check(d, "reset", 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    #13 rst_n = 1'b1;
    tick;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].st, vt[i].fl, vt[i].iv, vt[i].clr, vt[i].a, vt[i].c);
      tick;
      for (int d = 0; d < 2; d++)
        check(d, $sformatf("vec%0d", i), vt[i].ev, vt[i].ea, vt[i].ec, vt[i].eb, vt[i].ef, vt[i].en);
    end

    drive(1, 0, 1, 0, 4'h9, 8'h44);
    tick;
    check(0, "stall1", 0, 0, 0, 1, 0, 4);
    check(1, "stall1", 1, 4'h5, 8'h13, 0, 0, 3);
    tick;
    check(0, "stall2", 0, 0, 0, 1, 0, 5);
    check(1, "stall2", 1, 4'h5, 8'h13, 0, 0, 3);
    drive(0, 0, 1, 0, 4'h9, 8'h44);
    tick;
    check(0, "unstall", 1, 4'h9, 8'h44, 0, 0, 5);
    check(1, "unstall", 1, 4'h9, 8'h44, 0, 0, 3);

    drive(0, 0, 0, 0, 4'h9, 8'h44);
    for (int i = 0; i < 20; i++) tick;
    for (int d = 0; d < 2; d++) check(d, "saturate", 0, 0, 0, 1, 0, 15);
    drive(0, 0, 0, 1, 4'h9, 8'h44);
    tick;
    for (int d = 0; d < 2; d++) check(d, "clr_vs_inc", 0, 0, 0, 1, 0, 0);

    drive(0, 1, 1, 0, 4'h5, 8'h13);
    tick;
    for (int d = 0; d < 2; d++) check(d, "preflush", 0, 0, 0, 1, 1, 1);
    drive(0, 0, 1, 0, 4'h5, 8'h13);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check(d, "midflush_rst", 0, 0, 0, 1, 0, 0);
    #3 rst_n = 1'b1;
    tick;
    tick;
    for (int d = 0; d < 2; d++) check(d, "post_rst", 1, 4'h5, 8'h13, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
